dds_sweep_gen: RTL and testbench

DDS_SWEEP_GEN -- requirements
Module: dds_sweep_gen

---
 rtl/dds_sweep_gen.sv | 189 ++++++++++++++++++
 tb/tb_dds_sweep_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_gen.sv
// ---------------------------------------------------------------------------
// dds_sweep_gen
//
// Direct digital synthesis waveform generator with an optional linear
// frequency up-sweep. A phase accumulator advances by the current frequency
// word on every enabled cycle. Its top bits plus a phase offset address an
// external sine ROM, or feed simple square/triangle/sawtooth shapers. The
// sample path is a three-stage pipeline so that the ROM's one-cycle read
// latency lines up with the other waveforms.
//
// Ports
//   sys_clk, sys_rst   single rising-edge clock, synchronous active-high reset
//   enable             advances the accumulator and the sweep dwell counter
//   wave_select        one-hot: 0001 sine, 0010 square, 0100 triangle,
//                      1000 sawtooth; any other code selects sine
//   cfg_valid/ready    configuration handshake (ready only while not sweeping)
//   cfg_freq           start frequency word
//   cfg_phase          phase offset added to the ROM address
//   cfg_sweep_en       request a linear up-sweep
//   cfg_sweep_step     frequency increment applied once per dwell period
//   cfg_sweep_stop     sweep end frequency
//   sine_rom_addr      registered address to the external sine ROM
//   sine_rom_data      ROM read data, one cycle after the address
//   data_out           registered output sample
//   data_valid         enable delayed by three cycles
//   sweep_done         one-cycle pulse when a sweep finishes
// ---------------------------------------------------------------------------
module dds_sweep_gen #(
    parameter int                 ACC_W     = 32,
    parameter int                 PHASE_W   = 12,
    parameter int                 DATA_W    = 8,
    parameter logic [ACC_W-1:0]   FREQ_INIT = 32'd419430,
    parameter int                 DWELL     = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  enable,
    input  logic [3:0]            wave_select,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ACC_W-1:0]      cfg_freq,
    input  logic [PHASE_W-1:0]    cfg_phase,
    input  logic                  cfg_sweep_en,
    input  logic [ACC_W-1:0]      cfg_sweep_step,
    input  logic [ACC_W-1:0]      cfg_sweep_stop,
    output logic [PHASE_W-1:0]    sine_rom_addr,
    input  logic [DATA_W-1:0]     sine_rom_data,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid,
    output logic                  sweep_done
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [0:0]          state_q,     state_d;
    logic [ACC_W-1:0]    acc_q,       acc_d;
    logic [ACC_W-1:0]    freq_cur_q,  freq_cur_d;
    logic [PHASE_W-1:0]  phase_off_q, phase_off_d;
    logic [DW_W-1:0]     dwell_q,     dwell_d;
    logic [ACC_W-1:0]    step_q,      step_d;
    logic [ACC_W-1:0]    stop_q,      stop_d;
    logic                sweep_done_q, sweep_done_d;

    logic [PHASE_W-1:0]  p_q;
    logic [PHASE_W-1:0]  p2_q;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic [2:0]          vld_q;

    logic                accept;
    logic [ACC_W:0]      sweep_sum;

    // Phase bits below the sample width are not needed by any waveform.
    logic [PHASE_W-1:0]  unused_p2_bits;
    assign unused_p2_bits = p2_q;

    assign cfg_ready     = (state_q == ST_RUN);
    assign accept        = cfg_valid && cfg_ready;
    assign sweep_sum     = {1'b0, freq_cur_q} + {1'b0, step_q};
    assign sine_rom_addr = p_q;
    assign data_out      = data_q;
    assign data_valid    = vld_q[2];
    assign sweep_done    = sweep_done_q;

    // Control path: configuration handshake, accumulator and the sweep FSM.
    // A new configuration restarts the accumulator and dwell counter and
    // captures step/stop so the sweep is immune to later cfg_* changes.
    // The one-bit carry of sweep_sum catches a step that wraps past 2^ACC_W.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        freq_cur_d   = freq_cur_q;
        phase_off_d  = phase_off_q;
        dwell_d      = dwell_q;
        step_d       = step_q;
        stop_d       = stop_q;
        sweep_done_d = 1'b0;

        if (accept) begin
            freq_cur_d  = cfg_freq;
            phase_off_d = cfg_phase;
            acc_d       = '0;
            dwell_d     = '0;
            step_d      = cfg_sweep_step;
            stop_d      = cfg_sweep_stop;
            if (cfg_sweep_en) begin
                if (cfg_sweep_stop > cfg_freq) begin
                    state_d = ST_SWEEP;
                end else begin
                    sweep_done_d = 1'b1;
                end
            end
        end else begin
            if (enable) begin
                acc_d = acc_q + freq_cur_q;
            end
            if ((state_q == ST_SWEEP) && enable) begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (sweep_sum[ACC_W] || (sweep_sum[ACC_W-1:0] >= stop_q)) begin
                        freq_cur_d   = stop_q;
                        sweep_done_d = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        freq_cur_d   = sweep_sum[ACC_W-1:0];
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
        end
    end

    // Output shaper for stage 3. The ROM word returns aligned with p2_q,
    // so every waveform is derived from the same phase sample.
    always_comb begin
        data_d = sine_rom_data;
        case (wave_select)
            4'b0010: data_d = p2_q[PHASE_W-1] ? '0 : '1;
            4'b0100: data_d = p2_q[PHASE_W-1] ? ~p2_q[PHASE_W-2 -: DATA_W]
                                              :  p2_q[PHASE_W-2 -: DATA_W];
            4'b1000: data_d = p2_q[PHASE_W-1 -: DATA_W];
            default: data_d = sine_rom_data;
        endcase
    end

    // Control registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_RUN;
            acc_q        <= '0;
            freq_cur_q   <= FREQ_INIT;
            phase_off_q  <= '0;
            dwell_q      <= '0;
            step_q       <= '0;
            stop_q       <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            freq_cur_q   <= freq_cur_d;
            phase_off_q  <= phase_off_d;
            dwell_q      <= dwell_d;
            step_q       <= step_d;
            stop_q       <= stop_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // Sample pipeline. It shifts every cycle regardless of enable; the
    // valid shift register marks which outputs came from enabled cycles.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            p_q    <= '0;
            p2_q   <= '0;
            data_q <= '0;
            vld_q  <= '0;
        end else begin
            p_q    <= acc_q[ACC_W-1 -: PHASE_W] + phase_off_q;
            p2_q   <= p_q;
            data_q <= data_d;
            vld_q  <= {vld_q[1:0], enable};
        end
    end

endmodule

// File: tb/tb_dds_sweep_gen.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_gen
//
// Directed bench for dds_sweep_gen. Stimulus tasks push the expected sample
// for every enabled cycle into a queue; an independent monitor pops and
// compares whenever data_valid is high. Control outputs (cfg_ready,
// sweep_done, current frequency) are checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_dds_sweep_gen;

    localparam int          ACC_W     = 32;
    localparam int          PHASE_W   = 12;
    localparam int          DATA_W    = 8;
    localparam logic [31:0] FREQ_INIT = 32'd419430;
    localparam int          DWELL     = 4;

    logic               sys_clk;
    logic               sys_rst;
    logic               enable;
    logic [3:0]         wave_select;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [ACC_W-1:0]   cfg_freq;
    logic [PHASE_W-1:0] cfg_phase;
    logic               cfg_sweep_en;
    logic [ACC_W-1:0]   cfg_sweep_step;
    logic [ACC_W-1:0]   cfg_sweep_stop;
    logic [PHASE_W-1:0] sine_rom_addr;
    logic [DATA_W-1:0]  sine_rom_data;
    logic [DATA_W-1:0]  data_out;
    logic               data_valid;
    logic               sweep_done;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0]  expQ[$];

    logic [ACC_W-1:0]   mAcc;
    logic [ACC_W-1:0]   mFreq;
    logic [PHASE_W-1:0] mPhase;

    dds_sweep_gen #(
        .ACC_W    (ACC_W),
        .PHASE_W  (PHASE_W),
        .DATA_W   (DATA_W),
        .FREQ_INIT(FREQ_INIT),
        .DWELL    (DWELL)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .enable        (enable),
        .wave_select   (wave_select),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_freq      (cfg_freq),
        .cfg_phase     (cfg_phase),
        .cfg_sweep_en  (cfg_sweep_en),
        .cfg_sweep_step(cfg_sweep_step),
        .cfg_sweep_stop(cfg_sweep_stop),
        .sine_rom_addr (sine_rom_addr),
        .sine_rom_data (sine_rom_data),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .sweep_done    (sweep_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Arbitrary but address-dependent ROM contents.
    function automatic logic [7:0] romFn(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
    endfunction

    // External ROM with one-cycle synchronous read.
    always @(posedge sys_clk) sine_rom_data <= romFn(sine_rom_addr);

    // Expected sample for the current model accumulator value.
    function automatic logic [7:0] expSample(input logic [31:0] acc,
                                             input logic [11:0] ph,
                                             input logic [3:0]  wave);
        logic [11:0] p;
        p = acc[31:20] + ph;
        case (wave)
            4'b0010: return p[11] ? 8'h00 : 8'hFF;
            4'b0100: return p[11] ? ~p[10:3] : p[10:3];
            4'b1000: return p[11:4];
            default: return romFn(p);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: samples away from the active edge.
    always @(negedge sys_clk) begin
        if (data_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_sample: got 0x%0h, expected no sample at %0t",
                         data_out, $time);
            end else begin
                checkOutput("sample", {24'h0, data_out}, {24'h0, expQ.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One enabled cycle: record the expected sample, then advance the model.
    task automatic enabledTick();
        expQ.push_back(expSample(mAcc, mPhase, wave_select));
        mAcc = mAcc + mFreq;
        tick();
    endtask

    // Offer one configuration while the DUT is in RUN.
    task automatic applyStimulus(input logic [31:0] freq, input logic [11:0] phase,
                                 input logic sweepEn, input logic [31:0] step,
                                 input logic [31:0] stop);
        cfg_freq       = freq;
        cfg_phase      = phase;
        cfg_sweep_en   = sweepEn;
        cfg_sweep_step = step;
        cfg_sweep_stop = stop;
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
        mAcc           = '0;
        mFreq          = freq;
        mPhase         = phase;
    endtask

    task automatic drain();
        enable = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        sys_rst        = 1'b1;
        enable         = 1'b0;
        wave_select    = 4'b1000;
        cfg_valid      = 1'b0;
        cfg_freq       = '0;
        cfg_phase      = '0;
        cfg_sweep_en   = 1'b0;
        cfg_sweep_step = '0;
        cfg_sweep_stop = '0;
        mAcc           = '0;
        mFreq          = FREQ_INIT;
        mPhase         = '0;

        // Reset state
        repeat (2) tick();
        checkOutput("rst_rom_addr", {20'h0, sine_rom_addr}, 32'h0);
        checkOutput("rst_data_out", {24'h0, data_out}, 32'h0);
        checkOutput("rst_data_valid", {31'h0, data_valid}, 32'h0);
        checkOutput("rst_sweep_done", {31'h0, sweep_done}, 32'h0);
        checkOutput("rst_freq", dut.freq_cur_q, FREQ_INIT);
        sys_rst = 1'b0;
        tick();
        checkOutput("rst_cfg_ready", {31'h0, cfg_ready}, 32'h1);

        // Sawtooth with latency check; runs past the 0xFF -> 0x00 wrap
        wave_select = 4'b1000;
        applyStimulus(32'h0100_0000, 12'h000, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        enable = 1'b1;
        enabledTick();
        checkOutput("lat_valid_1", {31'h0, data_valid}, 32'h0);
        enabledTick();
        checkOutput("lat_valid_2", {31'h0, data_valid}, 32'h0);
        enabledTick();
        checkOutput("lat_valid_3", {31'h0, data_valid}, 32'h1);
        checkOutput("saw_first", {24'h0, data_out}, 32'h00);
        enabledTick();
        checkOutput("saw_second", {24'h0, data_out}, 32'h01);
        repeat (256) enabledTick();
        drain();

        // Square at half the sample rate
        wave_select = 4'b0010;
        applyStimulus(32'h8000_0000, 12'h000, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        enable = 1'b1;
        repeat (8) enabledTick();
        drain();

        // Triangle, one full period
        wave_select = 4'b0100;
        applyStimulus(32'h0100_0000, 12'h000, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        enable = 1'b1;
        repeat (258) enabledTick();
        drain();

        // Sine with a phase offset and zero frequency
        wave_select = 4'b0001;
        applyStimulus(32'h0, 12'h400, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        checkOutput("phase_rom_addr", {20'h0, sine_rom_addr}, 32'h400);
        enable = 1'b1;
        repeat (6) enabledTick();
        checkOutput("phase_rom_addr_hold", {20'h0, sine_rom_addr}, 32'h400);
        checkOutput("phase_sine_value", {24'h0, data_out}, 32'hE1);
        drain();

        // Non-one-hot select falls back to sine
        wave_select = 4'b0011;
        applyStimulus(32'h0100_0000, 12'h400, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        enable = 1'b1;
        repeat (20) enabledTick();
        drain();

        // Linear sweep 100 -> 300 in steps of 50, cfg_valid held meanwhile
        wave_select = 4'b1000;
        applyStimulus(32'd100, 12'h000, 1'b1, 32'd50, 32'd300);
        cfg_valid    = 1'b1;
        cfg_freq     = 32'd7;
        cfg_sweep_en = 1'b0;
        enable       = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checkOutput("sweep_freq", dut.freq_cur_q, 32'd100 + 32'd50 * 32'(k / 4));
            checkOutput("sweep_ready_low", {31'h0, cfg_ready}, 32'h0);
            checkOutput("sweep_done_low", {31'h0, sweep_done}, 32'h0);
            mFreq = 32'd100 + 32'd50 * 32'(k / 4);
            enabledTick();
        end
        cfg_valid = 1'b0;
        checkOutput("sweep_freq_end", dut.freq_cur_q, 32'd300);
        checkOutput("sweep_ready_end", {31'h0, cfg_ready}, 32'h1);
        checkOutput("sweep_done_pulse", {31'h0, sweep_done}, 32'h1);
        mFreq = 32'd300;
        enabledTick();
        checkOutput("sweep_done_clear", {31'h0, sweep_done}, 32'h0);
        drain();

        // Sweep requested with stop <= start
        applyStimulus(32'd500, 12'h000, 1'b1, 32'd50, 32'd300);
        checkOutput("nosweep_ready", {31'h0, cfg_ready}, 32'h1);
        checkOutput("nosweep_done", {31'h0, sweep_done}, 32'h1);
        checkOutput("nosweep_freq", dut.freq_cur_q, 32'd500);
        tick();
        checkOutput("nosweep_done_clear", {31'h0, sweep_done}, 32'h0);

        // Sweep step that overflows ACC_W clamps to stop
        applyStimulus(32'hFFFF_FF00, 12'h000, 1'b1, 32'h200, 32'hFFFF_FFFF);
        enable = 1'b1;
        for (int k = 0; k < DWELL; k++) begin
            checkOutput("ovf_freq", dut.freq_cur_q, 32'hFFFF_FF00);
            checkOutput("ovf_done_low", {31'h0, sweep_done}, 32'h0);
            enabledTick();
        end
        checkOutput("ovf_freq_clamp", dut.freq_cur_q, 32'hFFFF_FFFF);
        checkOutput("ovf_done_pulse", {31'h0, sweep_done}, 32'h1);
        checkOutput("ovf_ready", {31'h0, cfg_ready}, 32'h1);
        mFreq = 32'hFFFF_FFFF;
        enabledTick();
        checkOutput("ovf_done_clear", {31'h0, sweep_done}, 32'h0);
        drain();

        // Reset during the second sweep step, with a concurrent cfg offer
        applyStimulus(32'd100, 12'h000, 1'b1, 32'd50, 32'd300);
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mFreq = 32'd100 + 32'd50 * 32'(k / 4);
            enabledTick();
        end
        checkOutput("midrst_pre_freq", dut.freq_cur_q, 32'd150);
        sys_rst   = 1'b1;
        cfg_valid = 1'b1;
        cfg_freq  = 32'd1234;
        tick();
        checkOutput("midrst_freq", dut.freq_cur_q, FREQ_INIT);
        checkOutput("midrst_data_out", {24'h0, data_out}, 32'h0);
        checkOutput("midrst_valid", {31'h0, data_valid}, 32'h0);
        checkOutput("midrst_done", {31'h0, sweep_done}, 32'h0);
        checkOutput("midrst_ready", {31'h0, cfg_ready}, 32'h1);
        sys_rst   = 1'b0;
        cfg_valid = 1'b0;
        enable    = 1'b0;
        expQ.delete();
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("midrst_no_done", {31'h0, sweep_done}, 32'h0);
        end
        checkOutput("midrst_ready_after", {31'h0, cfg_ready}, 32'h1);

        checkOutput("queue_empty", 32'(expQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
